heading_display_ctrl: RTL

Sequences and shares a single iterative binary-to-BCD converter between two requesters, the compass heading and an auxiliary value such as the field magnitude or calibration offset, and drives the Nexys A7 8-digit seven-segment display. Both results are held in display registers and scanned continuously. The block sits between the heading computation and the board display pins.

---
 rtl/heading_display_pkg.sv | 20 ++
 rtl/dabble_bcd_iter.sv | 55 +++++
 rtl/heading_display_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/heading_display_pkg.sv
// Shared types and constants for the heading/aux BCD display controller.
package heading_display_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         MAX_DISP   = 999;

    // Active-low {g,f,e,d,c,b,a} patterns; entry 0 is the rightmost literal.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d > 4'd9) ? SEG_BLANK : SEG_TABLE[d];
    endfunction

endpackage

// File: rtl/dabble_bcd_iter.sv
// Iterative double-dabble converter: one add-3/shift step per cycle, VAL_W steps.
module dabble_bcd_iter #(
    parameter int VAL_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [12+VAL_W-1:0] sh_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                run_reg;
    logic [11:0]         bcd_adj;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = sh_reg[VAL_W + 4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_reg  <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (start) begin
            sh_reg  <= {12'd0, bin};
            cnt_reg <= CNT_W'(VAL_W);
            run_reg <= 1'b1;
        end else if (run_reg) begin
            sh_reg  <= {bcd_adj, sh_reg[VAL_W-1:0]} << 1;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1))
                run_reg <= 1'b0;
        end
    end

    // done marks the cycle whose edge completes the final step.
    assign busy     = run_reg;
    assign done     = run_reg && (cnt_reg == CNT_W'(1));
    assign hundreds = sh_reg[VAL_W+8 +: 4];
    assign tens     = sh_reg[VAL_W+4 +: 4];
    assign ones     = sh_reg[VAL_W   +: 4];

endmodule

// File: rtl/heading_display_ctrl.sv
// Shares one BCD converter between heading and aux requesters and scans both
// results onto the 8-digit seven-segment display.
module heading_display_ctrl
    import heading_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100_000,
    parameter int VAL_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] hdg_val,
    input  logic             hdg_valid,
    input  logic [VAL_W-1:0] aux_val,
    input  logic             aux_valid,
    output logic             busy,
    output logic [7:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    state_t           state_reg;
    logic             gnt_aux_reg, last_aux_reg, busy_reg;
    logic             hdg_flag_reg, aux_flag_reg;
    logic [VAL_W-1:0] hdg_pend_reg, aux_pend_reg, cur_val_reg;
    logic [11:0]      hdg_bank_reg, aux_bank_reg, hdg_bank_next, aux_bank_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [7:0]       an_reg;
    logic [6:0]       seg_reg;

    logic             conv_busy, conv_done;
    logic [3:0]       conv_h, conv_t, conv_o;

    function automatic logic [VAL_W-1:0] clamp(input logic [VAL_W-1:0] v);
        return (v > VAL_W'(MAX_DISP)) ? VAL_W'(MAX_DISP) : v;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [IDX_W-1:0] idx,
                                             input logic [11:0] hb,
                                             input logic [11:0] ab);
        logic [11:0] b;
        b = idx[IDX_W-1] ? ab : hb;
        case (idx[1:0])
            2'd0:    return seg_of(b[3:0]);
            2'd1:    return (b[11:4] == 8'd0) ? SEG_BLANK : seg_of(b[7:4]);
            2'd2:    return (b[11:8] == 4'd0) ? SEG_BLANK : seg_of(b[11:8]);
            default: return SEG_BLANK;
        endcase
    endfunction

    // A same-cycle strobe counts as a request so IDLE can go straight to LOAD.
    logic req_h, req_a, pick_aux;
    assign req_h    = hdg_flag_reg | hdg_valid;
    assign req_a    = aux_flag_reg | aux_valid;
    assign pick_aux = req_a && (!req_h || !last_aux_reg);

    dabble_bcd_iter #(.VAL_W(VAL_W)) u_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (state_reg == LOAD),
        .bin      (cur_val_reg),
        .busy     (conv_busy),
        .done     (conv_done),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o)
    );

    always_comb begin
        hdg_bank_next = hdg_bank_reg;
        aux_bank_next = aux_bank_reg;
        if (state_reg == DONE) begin
            if (gnt_aux_reg) aux_bank_next = {conv_h, conv_t, conv_o};
            else             hdg_bank_next = {conv_h, conv_t, conv_o};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_aux_reg  <= 1'b0;
            last_aux_reg <= 1'b1;
            busy_reg     <= 1'b0;
            hdg_flag_reg <= 1'b0;
            aux_flag_reg <= 1'b0;
            hdg_pend_reg <= '0;
            aux_pend_reg <= '0;
            cur_val_reg  <= '0;
            hdg_bank_reg <= '0;
            aux_bank_reg <= '0;
        end else begin
            if (hdg_valid) begin
                hdg_pend_reg <= clamp(hdg_val);
                hdg_flag_reg <= 1'b1;
            end
            if (aux_valid) begin
                aux_pend_reg <= clamp(aux_val);
                aux_flag_reg <= 1'b1;
            end
            hdg_bank_reg <= hdg_bank_next;
            aux_bank_reg <= aux_bank_next;
            case (state_reg)
                IDLE: if (req_h || req_a) begin
                    state_reg    <= LOAD;
                    busy_reg     <= 1'b1;
                    gnt_aux_reg  <= pick_aux;
                    last_aux_reg <= pick_aux;
                    if (pick_aux) begin
                        aux_flag_reg <= 1'b0;
                        cur_val_reg  <= aux_valid ? clamp(aux_val) : aux_pend_reg;
                    end else begin
                        hdg_flag_reg <= 1'b0;
                        cur_val_reg  <= hdg_valid ? clamp(hdg_val) : hdg_pend_reg;
                    end
                end
                LOAD:  state_reg <= SHIFT;
                SHIFT: if (conv_done || !conv_busy) state_reg <= DONE;
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // an/seg are computed from the next index and next bank so they change together.
    assign idx_next = (cnt_reg == CNT_W'(DIGIT_CYCLES - 1)) ? idx_reg + 1'b1 : idx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            an_reg  <= 8'hFF;
            seg_reg <= SEG_BLANK;
        end else begin
            cnt_reg <= (cnt_reg == CNT_W'(DIGIT_CYCLES - 1)) ? '0 : cnt_reg + 1'b1;
            idx_reg <= idx_next;
            an_reg  <= ~(8'd1 << idx_next);
            seg_reg <= digit_seg(idx_next, hdg_bank_next, aux_bank_next);
        end
    end

    assign busy = busy_reg;
    assign an   = an_reg;
    assign seg  = seg_reg;
    assign dp   = 1'b1;

endmodule
